// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction-fetch unit and its prefetch buffer.
package ifu_pkg;

   localparam int INSN_W  = 32;
   localparam int PC_STEP = 4;
   localparam int PC_W    = 32;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INSN_W-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is presented combinationally from storage.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end

   // NOTE: storage is deliberately not reset; validity comes only from the reset pointers and count.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: sequential request generation, in-order PC tagging of responses,
// and redirect handling that discards responses belonging to the abandoned stream.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   output logic              o_imem_req_valid,
   input  logic              i_imem_req_ready,
   output logic [XLEN-1:0]   o_imem_req_addr,
   input  logic              i_imem_rsp_valid,
   input  logic [INSN_W-1:0] i_imem_rsp_data,
   input  logic              i_redirect_valid,
   input  logic [XLEN-1:0]   i_redirect_target,
   output logic              o_inst_valid,
   input  logic              i_inst_ready,
   output logic [INSN_W-1:0] o_inst_data,
   output logic [XLEN-1:0]   o_inst_pc
);

   localparam int CW = $clog2(DEPTH);
   localparam int EW = XLEN + INSN_W;

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW:0]     r_outstanding;
   logic [CW:0]     r_drop_cnt;
   logic [CW:0]     w_inflight_nxt;
   logic [CW:0]     w_redirect_drop;
   logic [CW:0]     w_fifo_count;
   logic [XLEN-1:0] w_target;
   logic [EW-1:0]   w_fifo_rdata;
   logic            w_credit_ok;
   logic            w_req_fire;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_empty;
   logic            w_fifo_full;

   assign w_target    = i_redirect_target & ~XLEN'(3);
   assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CW+2)'(DEPTH);
   assign w_req_fire  = o_imem_req_valid && i_imem_req_ready;
   assign w_pop       = o_inst_valid && i_inst_ready;

   assign w_inflight_nxt  = r_outstanding + (CW+1)'(w_req_fire) - (CW+1)'(i_imem_rsp_valid);
   // A redirect cycle never accepts a request, so only the arriving response reduces the count.
   assign w_redirect_drop = r_outstanding - (CW+1)'(i_imem_rsp_valid);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= RUN;
      else         r_state <= w_state_nxt;
   end

   // NOTE: every output of this block is given a default first so no latch can be inferred.
   always_comb begin
      w_state_nxt      = r_state;
      o_imem_req_valid = 1'b0;
      o_inst_valid     = 1'b0;
      w_push           = 1'b0;
      if (!i_reset) begin
         o_inst_valid = !w_fifo_empty && !i_redirect_valid;
         if (i_redirect_valid) begin
            w_state_nxt = (w_redirect_drop != '0) ? DRAIN : RUN;
         end else begin
            case (r_state)
               RUN: begin
                  o_imem_req_valid = w_credit_ok;
                  w_push           = i_imem_rsp_valid;
               end
               DRAIN: begin
                  if (i_imem_rsp_valid && r_drop_cnt == (CW+1)'(1)) w_state_nxt = RUN;
               end
               default: w_state_nxt = RUN;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_inflight_nxt;
         if (i_redirect_valid) begin
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
            r_drop_cnt <= w_redirect_drop;
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
            if (r_state == DRAIN && i_imem_rsp_valid) r_drop_cnt <= r_drop_cnt - (CW+1)'(1);
         end
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_data  ({r_rsp_pc, i_imem_rsp_data}),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .o_data  (w_fifo_rdata),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign o_imem_req_addr = r_fetch_pc;
   assign o_inst_pc       = w_fifo_rdata[EW-1:INSN_W];
   assign o_inst_data     = w_fifo_rdata[INSN_W-1:0];

   a_rsp_expected: assert property (@(posedge i_clk) disable iff (i_reset)
      i_imem_rsp_valid |-> (r_outstanding != '0));
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
      w_push |-> !w_fifo_full);

endmodule
